psum_drain: RTL and testbench

- Output-side collector for the systolic array. Sits between the array's partial-sum stream (data_out/valid_out) and the downstream writeback path.
- Discards the programmable pipeline warm-up beats and optionally reverses word order within each beat.
- Buffers beats in a FIFO with a valid/ready output, counts beats to a programmed total, and flags the last beat and completion.
- Replaces bench-side output counting with synthesizable logic. Generalised in word count, width, FIFO depth and ordering mode.

---
 rtl/psum_drain_pkg.sv | 30 +++
 rtl/psum_sync_fifo.sv | 54 +++++
 rtl/psum_drain.sv | 141 ++++++++++++++
 tb/tb_psum_drain.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg
//   Shared types and defaults for the partial-sum drain block.
//   - state_t       : drain controller states
//   - beat_t        : one beat at the default geometry
//   - reverse_words : word-order reversal within a default-geometry beat
package psum_drain_pkg;

    localparam int C_WIDTH          = 32;
    localparam int C_WORDS_PER_BEAT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    typedef logic [C_WORDS_PER_BEAT*C_WIDTH-1:0] beat_t;

    // Output word v takes input word C_WORDS_PER_BEAT-1-v.
    function automatic beat_t reverse_words(input beat_t b);
        beat_t r;
        for (int v = 0; v < C_WORDS_PER_BEAT; v++) begin
            r[v*C_WIDTH +: C_WIDTH] = b[(C_WORDS_PER_BEAT-1-v)*C_WIDTH +: C_WIDTH];
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_sync_fifo.sv
// psum_sync_fifo
//   Show-ahead synchronous FIFO. A word pushed at edge t is visible on
//   rd_data with empty=0 right after edge t. Push and pop may coincide,
//   including at full.
//   Ports: clk, rst (sync, active high), push, pop, wr_data,
//          rd_data (zero while empty), full, empty.
module psum_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; empty gates rd_data, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// psum_drain
//   Collects the systolic array's partial-sum beats: discards cfg_skip
//   warm-up beats, keeps cfg_total beats (optionally word-reversed),
//   buffers them behind a valid/ready port and reports completion.
//   Ports: clk, rst (sync, active high);
//          cfg_start/cfg_skip/cfg_total/cfg_reverse : run configuration;
//          in_data/in_valid                          : array stream, no stall;
//          out_data/out_valid/out_ready/out_last     : buffered output;
//          busy, done, overflow (sticky), beat_count : status.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int C_WIDTH        = psum_drain_pkg::C_WIDTH,
    parameter int WORDS_PER_BEAT = C_WORDS_PER_BEAT,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_W          = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_start,
    input  logic [CNT_W-1:0]                  cfg_skip,
    input  logic [CNT_W-1:0]                  cfg_total,
    input  logic                              cfg_reverse,
    input  logic [WORDS_PER_BEAT*C_WIDTH-1:0] in_data,
    input  logic                              in_valid,
    output logic [WORDS_PER_BEAT*C_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  beat_count
);

    localparam int BW = WORDS_PER_BEAT * C_WIDTH;

    state_t           state;
    logic [CNT_W-1:0] skip_left;
    logic [CNT_W-1:0] total_q;
    logic             reverse_q;

    logic [BW-1:0]    rev_data;
    logic [BW-1:0]    wr_beat;
    logic             wr_last;
    logic             push;
    logic             pop;
    logic             room;
    logic             fifo_full;
    logic             fifo_empty;
    logic [BW:0]      rd_word;

    for (genvar v = 0; v < WORDS_PER_BEAT; v++) begin : g_rev
        assign rev_data[v*C_WIDTH +: C_WIDTH] = in_data[(WORDS_PER_BEAT-1-v)*C_WIDTH +: C_WIDTH];
    end

    assign wr_beat   = reverse_q ? rev_data : in_data;
    assign wr_last   = (beat_count == total_q - CNT_W'(1));
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the beat when the head leaves in the same cycle.
    assign room      = !fifo_full || pop;
    assign push      = (state == COLLECT) && in_valid && room;
    assign out_data  = rd_word[BW-1:0];
    assign out_last  = rd_word[BW];

    psum_sync_fifo #(
        .WIDTH (BW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({wr_last, wr_beat}),
        .rd_data (rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            skip_left  <= '0;
            total_q    <= '0;
            reverse_q  <= 1'b0;
            beat_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_start) begin
                        skip_left  <= cfg_skip;
                        total_q    <= cfg_total;
                        reverse_q  <= cfg_reverse;
                        beat_count <= '0;
                        overflow   <= 1'b0;
                        if (cfg_skip != '0) begin
                            state <= SKIP;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else if (cfg_total != '0) begin
                            state <= COLLECT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (in_valid) begin
                        skip_left <= skip_left - CNT_W'(1);
                        if (skip_left == CNT_W'(1)) state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        // Dropped beats still count so the run always terminates.
                        beat_count <= beat_count + CNT_W'(1);
                        if (!room) overflow <= 1'b1;
                        if (beat_count + CNT_W'(1) == total_q) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain
//   Directed bench for psum_drain (FIFO_DEPTH=4). A negedge monitor checks
//   every accepted output beat against an expected-beat queue.
module tb_psum_drain;

    localparam int CW = 32;
    localparam int WB = 4;
    localparam int BW = CW * WB;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic [CNT_W-1:0] cfg_skip;
    logic [CNT_W-1:0] cfg_total;
    logic             cfg_reverse;
    logic [BW-1:0]    in_data;
    logic             in_valid;
    logic [BW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] beat_count;

    psum_drain #(
        .C_WIDTH        (CW),
        .WORDS_PER_BEAT (WB),
        .FIFO_DEPTH     (4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_skip    (cfg_skip),
        .cfg_total   (cfg_total),
        .cfg_reverse (cfg_reverse),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .beat_count  (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        logic [BW-1:0] in_beat;
        logic          kept;
        logic [BW-1:0] exp_beat;
        logic          exp_last;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Scoreboard: every beat leaving the DUT must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h required none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_last", BW'(out_last), BW'(mon_e.last));
            end
        end
    end

    function automatic logic [BW-1:0] mk_beat(input int k);
        logic [BW-1:0] b;
        for (int v = 0; v < WB; v++) b[v*CW +: CW] = 32'h5A00_0000 | CW'(k << 8) | CW'(v);
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int skip, input int total, input logic rev);
        cfg_skip    = CNT_W'(skip);
        cfg_total   = CNT_W'(total);
        cfg_reverse = rev;
        cfg_start   = 1'b1;
        step();
        cfg_start   = 1'b0;
    endtask

    task automatic send(input logic [BW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [BW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && !done; i++) step();
        check({name, "_done"}, BW'(done), BW'(1));
        check({name, "_busy"}, BW'(busy), BW'(0));
        check({name, "_drained"}, BW'(exp_q.size()), BW'(0));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_out_valid"}, BW'(out_valid), BW'(0));
        check({name, "_out_last"}, BW'(out_last), BW'(0));
        check({name, "_out_data"}, out_data, '0);
        check({name, "_busy"}, BW'(busy), BW'(0));
        check({name, "_done"}, BW'(done), BW'(0));
        check({name, "_overflow"}, BW'(overflow), BW'(0));
        check({name, "_beat_count"}, BW'(beat_count), BW'(0));
    endtask

    vec_t vecs[7];

    initial begin
        // Skip 2, keep 5, reversed: word v of input beat k is 4k+v.
        vecs[0] = '{128'h00000003_00000002_00000001_00000000, 1'b0, '0, 1'b0};
        vecs[1] = '{128'h00000007_00000006_00000005_00000004, 1'b0, '0, 1'b0};
        vecs[2] = '{128'h0000000b_0000000a_00000009_00000008, 1'b1,
                    128'h00000008_00000009_0000000a_0000000b, 1'b0};
        vecs[3] = '{128'h0000000f_0000000e_0000000d_0000000c, 1'b1,
                    128'h0000000c_0000000d_0000000e_0000000f, 1'b0};
        vecs[4] = '{128'h00000013_00000012_00000011_00000010, 1'b1,
                    128'h00000010_00000011_00000012_00000013, 1'b0};
        vecs[5] = '{128'h00000017_00000016_00000015_00000014, 1'b1,
                    128'h00000014_00000015_00000016_00000017, 1'b0};
        vecs[6] = '{128'h0000001b_0000001a_00000019_00000018, 1'b1,
                    128'h00000018_00000019_0000001a_0000001b, 1'b1};

        rst = 1'b1; cfg_start = 1'b0; cfg_skip = '0; cfg_total = '0;
        cfg_reverse = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        check_reset_values("reset");

        // 1: skip and total with reversal, downstream always ready.
        out_ready = 1'b1;
        start(2, 5, 1'b1);
        check("t1_busy", BW'(busy), BW'(1));
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].kept) expect_beat(vecs[i].exp_beat, vecs[i].exp_last);
            send(vecs[i].in_beat);
        end
        wait_done("t1");
        check("t1_beat_count", BW'(beat_count), BW'(5));
        check("t1_overflow", BW'(overflow), BW'(0));

        // 2: backpressure, FIFO exactly filled then drained in order.
        out_ready = 1'b0;
        start(0, 4, 1'b0);
        check("t2_done_cleared", BW'(done), BW'(0));
        for (int k = 0; k < 4; k++) begin
            expect_beat(mk_beat(k), k == 3);
            send(mk_beat(k));
        end
        check("t2_head_valid", BW'(out_valid), BW'(1));
        check("t2_head_data", out_data, mk_beat(0));
        step(); step(); step();
        check("t2_head_stable", out_data, mk_beat(0));
        check("t2_busy_drain", BW'(busy), BW'(1));
        out_ready = 1'b1;
        wait_done("t2");
        check("t2_overflow", BW'(overflow), BW'(0));
        check("t2_beat_count", BW'(beat_count), BW'(4));

        // 3: overflow, beats 5 and 6 dropped, no out_last ever.
        out_ready = 1'b0;
        start(0, 6, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) expect_beat(mk_beat(10 + k), 1'b0);
            send(mk_beat(10 + k));
        end
        check("t3_overflow", BW'(overflow), BW'(1));
        check("t3_beat_count", BW'(beat_count), BW'(6));
        out_ready = 1'b1;
        wait_done("t3");
        check("t3_overflow_sticky", BW'(overflow), BW'(1));

        // 4: push into a full FIFO while the head pops in the same cycle.
        out_ready = 1'b0;
        start(0, 5, 1'b0);
        check("t4_overflow_cleared", BW'(overflow), BW'(0));
        for (int k = 0; k < 5; k++) expect_beat(mk_beat(20 + k), k == 4);
        for (int k = 0; k < 4; k++) send(mk_beat(20 + k));
        out_ready = 1'b1;
        send(mk_beat(24));
        wait_done("t4");
        check("t4_overflow", BW'(overflow), BW'(0));

        // 5: zero total finishes one cycle after the start pulse.
        start(0, 0, 1'b0);
        check("t5_done", BW'(done), BW'(1));
        check("t5_out_valid", BW'(out_valid), BW'(0));
        step();
        check("t5_out_valid_later", BW'(out_valid), BW'(0));

        // 6: reset during COLLECT, then a fresh run.
        out_ready = 1'b0;
        start(0, 8, 1'b0);
        for (int k = 0; k < 3; k++) send(mk_beat(30 + k));
        check("t6_pre_reset_valid", BW'(out_valid), BW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_values("t6_reset");
        out_ready = 1'b1;
        start(1, 2, 1'b0);
        expect_beat(mk_beat(41), 1'b0);
        expect_beat(mk_beat(42), 1'b1);
        for (int k = 0; k < 3; k++) send(mk_beat(40 + k));
        wait_done("t6");
        check("t6_beat_count", BW'(beat_count), BW'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
